// File: rtl/riscv_pkg.sv
// Shared RV32I fetch definitions: legal base opcodes, fetch FSM states and the
// instruction width.
package riscv_pkg;

  localparam int INST_W = 32;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'd3,
    OP_IMM    = 7'd19,
    OP_AUIPC  = 7'd23,
    OP_STORE  = 7'd35,
    OP_REG    = 7'd51,
    OP_LUI    = 7'd55,
    OP_BRANCH = 7'd99,
    OP_JALR   = 7'd103,
    OP_JAL    = 7'd111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush that empties it in one cycle. Head data is
// read straight from storage, so it is registered and stable until popped.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem reads, a registered
// instruction buffer toward decode, and opcode screening that halts on illegal words.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReqValid,
  input  logic              imemReqReady,
  output logic [XLEN-1:0]   imemAddr,
  input  logic              imemRespValid,
  input  logic [INST_W-1:0] imemRespData,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirectPC,
  output logic              instValid,
  input  logic              instReady,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   instPC,
  output logic [6:0]        opCode,
  output logic              illegalInst,
  output logic              misaligned,
  output fetch_state_t      fsmState
);

  // Handshakes (imem request and decode output): a transfer happens on a clock
  // edge where valid && ready; valid never depends on ready, and the offered
  // payload stays put while valid is high and ready is low.

  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = CW + 1;

  fetch_state_t      state, state_nxt;
  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding, drop_cnt, occupancy, pcq_count;
  logic [CRW-1:0]    credit_used;
  logic [INST_W-1:0] head_inst;
  logic [XLEN-1:0]   head_pc, req_pc;
  logic              ibuf_empty, ibuf_full, pcq_empty, pcq_full;
  logic              redir, accept, resp_drop, resp_keep, push, pop, head_legal, mis_q;

  assign redir       = redirect && (state != IDLE);
  assign credit_used = {1'b0, outstanding} + {1'b0, occupancy};
  assign imemReqValid = (state == RUN) && !redir && (credit_used < CRW'(FIFO_DEPTH));
  assign accept      = imemReqValid && imemReqReady;
  assign resp_drop   = imemRespValid && (drop_cnt != '0);
  assign resp_keep   = imemRespValid && (drop_cnt == '0);
  assign head_legal  = is_legal_opcode(head_inst[6:0]);
  assign instValid   = (state == RUN) && !ibuf_empty && head_legal;
  assign pop         = instValid && instReady && !redir;
  assign push        = resp_keep && !redir;

  assign imemAddr    = pc;
  assign inst        = head_inst;
  assign instPC      = head_pc;
  assign opCode      = head_inst[6:0];
  assign illegalInst = (state == HALT);
  assign misaligned  = mis_q;
  assign fsmState    = state;

  // PCs of accepted reads, consumed in order as their words come back.
  fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_pcq (
    .clk(clk), .rst_n(rst_n), .flush(redir),
    .push(accept), .din(pc), .pop(push),
    .dout(req_pc), .empty(pcq_empty), .full(pcq_full), .count(pcq_count)
  );

  fetch_fifo #(.W(INST_W + XLEN), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk(clk), .rst_n(rst_n), .flush(redir),
    .push(push), .din({imemRespData, req_pc}), .pop(pop),
    .dout({head_inst, head_pc}), .empty(ibuf_empty), .full(ibuf_full), .count(occupancy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (!redir && !ibuf_empty && !head_legal) state_nxt = HALT;
      HALT:    if (redir) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      mis_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      mis_q <= redir && (redirectPC[1:0] != 2'b00);
      if (redir) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc          <= {redirectPC[XLEN-1:2], 2'b00};
        outstanding <= outstanding - CW'(imemRespValid);
        drop_cnt    <= outstanding - CW'(imemRespValid);
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        outstanding <= outstanding + CW'(accept) - CW'(imemRespValid);
        drop_cnt    <= drop_cnt - CW'(resp_drop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && ibuf_full && !pop));
  a_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding <= CW'(FIFO_DEPTH));
  a_drop_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= outstanding);
  a_pcq_sync: assert property (@(posedge clk) disable iff (!rst_n)
    !(accept && pcq_full) && (!push || !pcq_empty) && (pcq_count == outstanding - drop_cnt));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a request/response memory model with redirect epochs.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        imemReqValid, imemReqReady, imemRespValid, redirect;
  logic        instValid, instReady, illegalInst, misaligned;
  logic [31:0] imemAddr, imemRespData, redirectPC, inst, instPC;
  logic [6:0]  opCode;
  fetch_state_t fsmState;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .redirect(redirect), .redirectPC(redirectPC),
    .instValid(instValid), .instReady(instReady), .inst(inst), .instPC(instPC),
    .opCode(opCode), .illegalInst(illegalInst), .misaligned(misaligned), .fsmState(fsmState)
  );

  // second instance for the PC wrap-around from a high reset PC
  logic        w_req_valid, w_resp_valid, w_inst_valid, w_illegal, w_mis;
  logic [31:0] w_addr, w_inst, w_inst_pc;
  logic [6:0]  w_op;
  fetch_state_t w_state;
  logic        start_wrap = 1'b0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imemReqValid(w_req_valid), .imemReqReady(1'b1), .imemAddr(w_addr),
    .imemRespValid(w_resp_valid), .imemRespData(32'h0000_0013),
    .redirect(1'b0), .redirectPC(32'h0),
    .instValid(w_inst_valid), .instReady(1'b1), .inst(w_inst), .instPC(w_inst_pc),
    .opCode(w_op), .illegalInst(w_illegal), .misaligned(w_mis), .fsmState(w_state)
  );

  // scoreboard state
  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        inflight[$];   // accepted reads the memory model still owes
  logic [31:0] exp_q[$];      // PCs expected at the decode port, in order
  logic [31:0] exp_req_pc;
  logic [31:0] illegal_pc = 32'hFFFF_FFFF;
  int          epoch, cyc, last_due, first_valid_cyc, acc_cnt;
  bit          halted, exp_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    int k;
    if (a == illegal_pc) return 32'h0000_007F;
    k = int'(a[6:2]) % 9;
    case (k)
      0: op = 7'd3;   1: op = 7'd19;  2: op = 7'd23;
      3: op = 7'd35;  4: op = 7'd51;  5: op = 7'd55;
      6: op = 7'd99;  7: op = 7'd103; default: op = 7'd111;
    endcase
    return {a[26:2], op};
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_reqv"}, imemReqValid, 0);
    check_eq({tag, "_instv"}, instValid, 0);
    check_eq({tag, "_ill"}, illegalInst, 0);
    check_eq({tag, "_mis"}, misaligned, 0);
    check_eq({tag, "_inst"}, inst, 0);
    check_eq({tag, "_instpc"}, instPC, 0);
    check_eq({tag, "_opcode"}, {25'b0, opCode}, 0);
    check_eq({tag, "_addr"}, imemAddr, RESET_PC);
  endtask

  // driver: reset asserts immediately and releases on a falling edge
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    redirect = 0; redirectPC = 0; imemReqReady = 0;
    imemRespValid = 0; imemRespData = 0; instReady = 0;
    #1;
    check_zero_outputs(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq({tag, "_idle_noreq"}, imemReqValid, 0);
    inflight.delete();
    exp_q.delete();
    exp_req_pc = RESET_PC;
    epoch = 0; last_due = 0; halted = 0; exp_mis = 0;
    cyc = 1;
  endtask

  // driver: one clock cycle of stimulus with model update and checks
  task automatic run_cycle(input bit r, input logic [31:0] rpc, input bit rdy,
                           input bit irdy, input int lat);
    bit resp, exp_iv, exp_rv, acc, hs, ill_front;
    req_t f;
    int d;
    @(negedge clk);
    resp = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imemRespValid = resp;
    imemRespData  = resp ? mem_word(inflight[0].addr) : 32'h0;
    redirect = r; redirectPC = rpc; imemReqReady = rdy; instReady = irdy;
    #1;
    exp_iv = !halted && (exp_q.size() > 0) && (exp_q[0] != illegal_pc);
    check_eq("instValid", instValid, exp_iv);
    if (exp_iv) begin
      check_eq("instPC", instPC, exp_q[0]);
      check_eq("inst", inst, mem_word(exp_q[0]));
      check_eq("opCode", {25'b0, opCode}, mem_word(exp_q[0]) & 32'h7F);
    end
    exp_rv = !halted && !r && ((inflight.size() + exp_q.size()) < DEPTH);
    check_eq("imemReqValid", imemReqValid, exp_rv);
    check_eq("illegalInst", illegalInst, halted);
    check_eq("misaligned", misaligned, exp_mis);
    if (instValid && first_valid_cyc < 0) first_valid_cyc = cyc;

    acc = imemReqValid && rdy;
    hs  = instValid && irdy && !r;
    if (acc) begin
      check_eq("imemAddr", imemAddr, exp_req_pc);
      acc_cnt++;
    end
    ill_front = !halted && (exp_q.size() > 0) && (exp_q[0] == illegal_pc);
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    if (resp) begin
      f = inflight.pop_front();
      if (f.epoch == epoch && !r) exp_q.push_back(f.addr);
    end
    if (acc) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      inflight.push_back('{exp_req_pc, epoch, d});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    exp_mis = r && (rpc[1:0] != 2'b00);
    if (r) begin
      epoch++;
      exp_q.delete();
      exp_req_pc = {rpc[31:2], 2'b00};
      halted = 0;
    end else if (ill_front) begin
      halted = 1;
    end
    cyc++;
  endtask

  // wrap-around instance: answers each accepted read one cycle later
  initial begin
    logic [31:0] wexp [3];
    int wn;
    bit w_acc_prev;
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    wn = 0; w_acc_prev = 0; w_resp_valid = 0;
    wait (start_wrap);
    for (int i = 0; i < 20 && wn < 3; i++) begin
      @(negedge clk);
      w_resp_valid = w_acc_prev;
      #1;
      if (w_req_valid) begin
        check_eq("wrap_addr", w_addr, wexp[wn]);
        wn++;
      end
      w_acc_prev = w_req_valid;
    end
    w_resp_valid = 0;
    check_eq("wrap_count", wn, 3);
  end

  initial begin
    int budget;
    first_valid_cyc = -1;
    acc_cnt = 0;
    #2;
    do_reset("reset");
    start_wrap = 1'b1;

    // back-to-back fetch, one-cycle memory
    for (int i = 0; i < 12; i++) run_cycle(0, 0, 1, 1, 1);
    check_eq("first_valid_cycle", first_valid_cyc, 3);

    // decode stalled for 10 cycles
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 1, 0, 1);
    check_eq("stall_reqs_le2", (acc_cnt <= 2), 1);
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 1, 1, 1);

    // redirect with two reads in flight
    budget = 0;
    while (inflight.size() < 2 && budget < 20) begin
      run_cycle(0, 0, 1, 1, 3);
      budget++;
    end
    check_eq("two_outstanding", inflight.size(), 2);
    run_cycle(1, 32'h100, 1, 1, 3);
    for (int i = 0; i < 12; i++) run_cycle(0, 0, 1, 1, 1);

    // illegal word at 0xC halts fetch; redirect resumes it
    illegal_pc = 32'hC;
    run_cycle(1, 32'h0, 1, 1, 1);
    budget = 0;
    while (!illegalInst && budget < 30) begin
      run_cycle(0, 0, 1, 1, 1);
      budget++;
    end
    check_eq("halt_reached", illegalInst, 1);
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 1, 1, 1);
    run_cycle(1, 32'h40, 1, 1, 1);
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 1, 1, 1);

    // misaligned redirect target
    run_cycle(1, 32'h102, 1, 1, 1);
    for (int i = 0; i < 8; i++) run_cycle(0, 0, 1, 1, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit r;
      logic [31:0] t;
      r = ($urandom_range(0, 39) == 0);
      t = {20'h0, 10'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      run_cycle(r, t, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                $urandom_range(1, 4));
    end

    // reset in the middle of a burst, away from any clock edge
    #2;
    do_reset("midreset");
    for (int i = 0; i < 10; i++) run_cycle(0, 0, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
